sample_lift: RTL and testbench

SAMPLE_LIFT -- requirements
Module: sample_lift

---
 rtl/sample_lift_pkg.sv | 28 ++
 rtl/sample_lift_residue_negate.sv | 44 ++++
 rtl/sample_lift.sv | 113 +++++++++++
 tb/tb_sample_lift.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_lift_pkg.sv
// Shared types and constants for the sample_lift polynomial lifter.
// Optional CBD magnitude range check is enabled by defining SAMPLE_LIFT_RANGE_CHECK_EN.
package sample_lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_CBD     = 1'b0,
        MODE_TERNARY = 1'b1
    } mode_t;

    // Ternary 2-bit sample codes; TERN_BAD is the one illegal encoding.
    localparam logic [1:0] TERN_ZERO = 2'd0;
    localparam logic [1:0] TERN_POS  = 2'd1;
    localparam logic [1:0] TERN_BAD  = 2'd2;
    localparam logic [1:0] TERN_NEG  = 2'd3;

    // Largest legal CBD magnitude for the sampler feeding this block.
    localparam logic [4:0] CBD_BOUND = 5'd21;

    localparam int DRAIN_W = 3;

endpackage

// File: rtl/sample_lift_residue_negate.sv
// Combinational decode of one CBD/ternary sample into a residue in [0, q).
// With SAMPLE_LIFT_RANGE_CHECK_EN defined, CBD magnitudes above CBD_BOUND also flag invalid.
module residue_negate
    import sample_lift_pkg::*;
#(
    parameter int LOGQ = 54
) (
    input  mode_t            mode,
    input  logic [5:0]       sample,
    input  logic [LOGQ-1:0]  q,
    output logic [LOGQ-1:0]  residue,
    output logic             invalid
);

    logic [LOGQ-1:0] mag;

    // The magnitude is widened before subtracting so q-m keeps every bit of q.
    assign mag = {{(LOGQ-5){1'b0}}, sample[4:0]};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        residue = '0;
        invalid = 1'b0;
        if (mode == MODE_CBD) begin
            if (sample[5] && (sample[4:0] != 5'd0)) begin
                residue = q - mag;
            end else if (!sample[5]) begin
                residue = mag;
            end
`ifdef SAMPLE_LIFT_RANGE_CHECK_EN
            invalid = (sample[4:0] > CBD_BOUND);
`endif
        end else begin
            case (sample[1:0])
                TERN_ZERO: residue = '0;
                TERN_POS:  residue = LOGQ'(1);
                TERN_NEG:  residue = q - LOGQ'(1);
                TERN_BAD:  invalid = 1'b1;
                default:   residue = '0;
            endcase
        end
    end

endmodule

// File: rtl/sample_lift.sv
// Streams N source samples through a fixed-latency read, lifts each to a residue mod q and writes it back.
// Define SAMPLE_LIFT_RANGE_CHECK_EN to also flag CBD magnitudes above the sampler bound.
module sample_lift
    import sample_lift_pkg::*;
#(
    parameter int LOGN   = 13,
    parameter int LOGQ   = 54,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LOGQ-1:0]  q,
    output logic [LOGN-1:0]  rd_addr,
    output logic             rd_en,
    input  logic [5:0]       rd_data,
    output logic [LOGN-1:0]  wr_addr,
    output logic [LOGQ-1:0]  wr_data,
    output logic             wea,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t               state_q;
    state_t               next_state;
    logic [LOGN-1:0]      addr_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [LOGQ-1:0]      q_q;
    mode_t                mode_q;
    logic                 accept;

    logic                 v_pipe [RD_LAT];
    logic [LOGN-1:0]      a_pipe [RD_LAT];

    logic [LOGQ-1:0]      residue;
    logic                 invalid;
    logic                 lane_valid;

    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign lane_valid = v_pipe[RD_LAT-1];

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) next_state = ST_RUN;
            ST_RUN:   if (addr_q == {LOGN{1'b1}}) next_state = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_W'(RD_LAT)) next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The last pipeline stage lines up with rd_data arriving RD_LAT cycles after its read.
    residue_negate #(.LOGQ(LOGQ)) u_negate (
        .mode    (mode_q),
        .sample  (rd_data),
        .q       (q_q),
        .residue (residue),
        .invalid (invalid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            q_q     <= '0;
            mode_q  <= MODE_CBD;
            wr_addr <= '0;
            wr_data <= '0;
            wea     <= 1'b0;
            err     <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) v_pipe[k] <= 1'b0;
        end else begin
            state_q <= next_state;
            if (accept) begin
                q_q     <= q;
                mode_q  <= mode_t'(mode);
                addr_q  <= '0;
                drain_q <= '0;
            end else if (state_q == ST_RUN) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == ST_DRAIN) drain_q <= drain_q + 1'b1;

            v_pipe[0] <= rd_en;
            for (int k = 1; k < RD_LAT; k++) v_pipe[k] <= v_pipe[k-1];

            wea <= lane_valid;
            if (lane_valid) begin
                wr_addr <= a_pipe[RD_LAT-1];
                wr_data <= residue;
            end

            if (accept) err <= 1'b0;
            else if (lane_valid && invalid) err <= 1'b1;
        end
    end

    // NOTE: the address pipeline is not reset; only the valid bits above decide whether it is used.
    always_ff @(posedge clk) begin
        a_pipe[0] <= rd_addr;
        for (int k = 1; k < RD_LAT; k++) a_pipe[k] <= a_pipe[k-1];
    end

    assign rd_addr = addr_q;
    assign rd_en   = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_sample_lift.sv
// Scoreboard bench for sample_lift (LOGN=3, RD_LAT=2); expectations follow SAMPLE_LIFT_RANGE_CHECK_EN when defined.
module tb_sample_lift;

    localparam int LOGN   = 3;
    localparam int LOGQ   = 54;
    localparam int RD_LAT = 2;
    localparam int N      = 8;

`ifdef SAMPLE_LIFT_RANGE_CHECK_EN
    localparam logic RANGE_ERR = 1'b1;
`else
    localparam logic RANGE_ERR = 1'b0;
`endif

    typedef struct {
        logic [LOGN-1:0] addr;
        logic [LOGQ-1:0] data;
        int              cyc;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [LOGQ-1:0]  q;
    logic [LOGN-1:0]  rd_addr;
    logic             rd_en;
    logic [5:0]       rd_data;
    logic [LOGN-1:0]  wr_addr;
    logic [LOGQ-1:0]  wr_data;
    logic             wea;
    logic             busy;
    logic             done;
    logic             err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t0         = 0;
    int rd_exp     = 0;

    wr_t        sb[$];
    logic [5:0] mem [N];
    logic [5:0] smp [N];
    logic [LOGQ-1:0] ex [N];
    logic [5:0] m0, m1;

    sample_lift #(.LOGN(LOGN), .LOGQ(LOGQ), .RD_LAT(RD_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .q       (q),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wea     (wea),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory with a two-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) m0 <= mem[rd_addr];
        m1 <= m0;
    end
    assign rd_data = m1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every read strobe and every write against the scoreboard.
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            check("rd_addr", 64'(rd_addr), 64'(rd_exp));
            check("rd_cycle", 64'(cyc), 64'(t0 + 1 + rd_exp));
            rd_exp++;
        end
        if (wea === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wea", 64'(wr_addr), 64'hdead);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic m, input logic [LOGQ-1:0] qv);
        for (int i = 0; i < N; i++) mem[i] = smp[i];
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        q     = qv;
        t0    = cyc;
        rd_exp = 0;
        for (int i = 0; i < N; i++) sb.push_back('{addr: LOGN'(i), data: ex[i], cyc: t0 + RD_LAT + 2 + i});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_poly(input logic m, input logic [LOGQ-1:0] qv, input logic exp_err, input int pulse_at);
        int  n;
        logic seen;
        issue(m, qv);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_after_start", 64'(done), 64'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                start = (pulse_at >= 0) && (cyc == t0 + pulse_at);
                if (start) begin
                    mode = ~m;
                    q    = 54'd5;
                end
                @(negedge clk);
                n++;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("done_cycle", 64'(cyc), 64'(t0 + 12));
        check("err_at_done", 64'(err), 64'(exp_err));
        check("busy_at_done", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_held", 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; q = '0;
        for (int i = 0; i < N; i++) mem[i] = 6'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wea", 64'(wea), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);

        // CBD, q=97: +3 -3 -0 +21 -21 +0 -1 +10
        smp = '{6'h03, 6'h23, 6'h20, 6'h15, 6'h35, 6'h00, 6'h21, 6'h0A};
        ex  = '{54'd3, 54'd94, 54'd0, 54'd21, 54'd76, 54'd0, 54'd96, 54'd10};
        run_poly(1'b0, 54'd97, 1'b0, -1);

        // Ternary, q=2^54-33: codes 0 1 3 2 3 1 0 0
        smp = '{6'd0, 6'd1, 6'd3, 6'd2, 6'd3, 6'd1, 6'd0, 6'd0};
        ex  = '{54'd0, 54'd1, 54'h3F_FFFF_FFFF_FFDE, 54'd0,
                54'h3F_FFFF_FFFF_FFDE, 54'd1, 54'd0, 54'd0};
        run_poly(1'b1, 54'h3F_FFFF_FFFF_FFDF, 1'b1, -1);

        // CBD, q=2^53+5, with a start pulse (mode/q changed) at cycle 4 of RUN; err must clear on start
        smp = '{6'h21, 6'h3F, 6'h01, 6'h20, 6'h35, 6'h15, 6'h30, 6'h10};
        ex  = '{54'h20_0000_0000_0004, 54'h1F_FFFF_FFFF_FFE6, 54'd1, 54'd0,
                54'h1F_FFFF_FFFF_FFF0, 54'd21, 54'h1F_FFFF_FFFF_FFF5, 54'd16};
        run_poly(1'b0, 54'h20_0000_0000_0005, 1'b0, 4);

        // Reset at cycle 5 of RUN: only addresses 0 and 1 reach the destination
        smp = '{6'h03, 6'h23, 6'h20, 6'h15, 6'h35, 6'h00, 6'h21, 6'h0A};
        ex  = '{54'd3, 54'd94, 54'd0, 54'd21, 54'd76, 54'd0, 54'd96, 54'd10};
        issue(1'b0, 54'd97);
        while (cyc != t0 + 5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rd_en", 64'(rd_en), 64'd0);
        check("midrst_wea", 64'(wea), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_rd_addr", 64'(rd_addr), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check("midrst_writes_left", 64'(sb.size()), 64'd6);
        sb.delete();
        repeat (4) @(negedge clk);
        check("midrst_quiet", 64'(wea), 64'd0);
        run_poly(1'b0, 54'd97, 1'b0, -1);

        // CBD magnitudes beyond the sampler bound, q=1000
        smp = '{6'h19, 6'h39, 6'h1F, 6'h3F, 6'h16, 6'h36, 6'h15, 6'h35};
        ex  = '{54'd25, 54'd975, 54'd31, 54'd969, 54'd22, 54'd978, 54'd21, 54'd979};
        run_poly(1'b0, 54'd1000, RANGE_ERR, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
